// File: rtl/dmem_lsu_if.sv
// Request/response bus between the core memory stage and the load/store unit,
// plus the unit's port pair towards the simple-dual-port data RAM.
interface dmem_lsu_if #(
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH_W = 12
);
  // core request
  logic                   i_req_valid;
  logic                   o_req_ready;
  logic                   i_req_we;
  logic [1:0]             i_req_size;
  logic                   i_req_unsigned;
  logic [31:0]            i_req_addr;
  logic [DATA_W-1:0]      i_req_wdata;
  // core response
  logic                   o_rsp_valid;
  logic [DATA_W-1:0]      o_rsp_rdata;
  logic                   o_rsp_err;
  // RAM write port and read port
  logic                   o_data_wena;
  logic [MEM_DEPTH_W-1:0] o_data_waddra;
  logic [DATA_W-1:0]      o_data_dina;
  logic [MEM_DEPTH_W-1:0] o_addrb;
  logic [DATA_W-1:0]      i_dout_b;

  // The load/store unit itself
  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    input  i_dout_b,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_data_wena, o_data_waddra, o_data_dina, o_addrb
  );

  // The environment: core stage plus RAM
  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
    output i_dout_b,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_data_wena, o_data_waddra, o_data_dina, o_addrb
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW onto a word RAM with
// read-modify-write for sub-word stores and write-to-read forwarding.
module dmem_lsu #(
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 4096,
  parameter int MEM_DEPTH_W = $clog2(MEM_DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  dmem_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LD   = 2'd1,
    ST_RMW  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic                   accept;
  logic                   req_err;
  logic [MEM_DEPTH_W-1:0] req_index;

  // Request captured at accept, used in LD/RMW
  logic [MEM_DEPTH_W-1:0] index_reg;
  logic [1:0]             addr_lo_reg;
  logic [1:0]             size_reg;
  logic                   uns_reg;
  logic [15:0]            wdata_reg;
  logic                   fwd_hit_reg;
  logic [DATA_W-1:0]      fwd_data_reg;

  // Registered outputs
  logic                   wena_reg, wena_next;
  logic [MEM_DEPTH_W-1:0] waddra_reg, waddra_next;
  logic [DATA_W-1:0]      dina_reg, dina_next;
  logic                   rsp_valid_reg, rsp_valid_next;
  logic                   rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0]      rsp_rdata_reg, rsp_rdata_next;

  logic [DATA_W-1:0]      rd_word;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [DATA_W-1:0]      load_val;
  logic [DATA_W-1:0]      merged_word;
  logic [3:0]             lane_hit;

  assign req_index       = bus.i_req_addr[MEM_DEPTH_W+1:2];
  assign bus.o_req_ready = (state_reg == ST_IDLE) && rst;
  assign accept          = bus.i_req_valid && bus.o_req_ready;
  assign bus.o_addrb     = (state_reg == ST_IDLE) ? req_index : index_reg;

  always_comb begin
    req_err = |bus.i_req_addr[31:MEM_DEPTH_W+2];
    case (bus.i_req_size)
      2'b01:   if (bus.i_req_addr[0]) req_err = 1'b1;
      2'b10:   if (|bus.i_req_addr[1:0]) req_err = 1'b1;
      2'b11:   req_err = 1'b1;
      default: ;
    endcase
  end

  // A write issued in the read-issue cycle is invisible to the read-first RAM
  assign rd_word  = fwd_hit_reg ? fwd_data_reg : bus.i_dout_b;
  assign byte_sel = rd_word[{addr_lo_reg, 3'b000} +: 8];
  assign half_sel = addr_lo_reg[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_val = uns_reg ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = uns_reg ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = rd_word;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi] = (size_reg == 2'b00) ? (addr_lo_reg == 2'(gi))
                                                : (addr_lo_reg[1] == 1'(gi / 2));
      assign merged_word[8*gi +: 8] =
          !lane_hit[gi]       ? rd_word[8*gi +: 8] :
          (size_reg == 2'b00) ? wdata_reg[7:0]     :
                                wdata_reg[8*(gi % 2) +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !req_err) begin
          if (!bus.i_req_we)                state_next = ST_LD;
          else if (bus.i_req_size != 2'b10) state_next = ST_RMW;
        end
      end
      ST_LD:   state_next = ST_IDLE;
      ST_RMW:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wena_next      = 1'b0;
    waddra_next    = waddra_reg;
    dina_next      = dina_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
          end else if (bus.i_req_we && bus.i_req_size == 2'b10) begin
            wena_next      = 1'b1;
            waddra_next    = req_index;
            dina_next      = bus.i_req_wdata;
            rsp_valid_next = 1'b1;
            rsp_rdata_next = '0;
          end
        end
      end
      ST_LD: begin
        rsp_valid_next = 1'b1;
        rsp_rdata_next = load_val;
      end
      ST_RMW: begin
        wena_next      = 1'b1;
        waddra_next    = index_reg;
        dina_next      = merged_word;
        rsp_valid_next = 1'b1;
        rsp_rdata_next = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wena_reg      <= 1'b0;
      waddra_reg    <= '0;
      dina_reg      <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      wena_reg      <= wena_next;
      waddra_reg    <= waddra_next;
      dina_reg      <= dina_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_reg    <= '0;
      addr_lo_reg  <= '0;
      size_reg     <= '0;
      uns_reg      <= 1'b0;
      wdata_reg    <= '0;
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else if (accept) begin
      index_reg    <= req_index;
      addr_lo_reg  <= bus.i_req_addr[1:0];
      size_reg     <= bus.i_req_size;
      uns_reg      <= bus.i_req_unsigned;
      wdata_reg    <= bus.i_req_wdata[15:0];
      fwd_hit_reg  <= wena_reg && (waddra_reg == req_index);
      fwd_data_reg <= dina_reg;
    end
  end

  assign bus.o_data_wena   = wena_reg;
  assign bus.o_data_waddra = waddra_reg;
  assign bus.o_data_dina   = dina_reg;
  assign bus.o_rsp_valid   = rsp_valid_reg;
  assign bus.o_rsp_err     = rsp_err_reg;
  assign bus.o_rsp_rdata   = rsp_rdata_reg;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: table of single transactions against a read-first
// RAM model, plus hand sequences for forwarding, back-to-back stores and reset.
module tb_dmem_lsu;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.DATA_W(32), .MEM_DEPTH_W(AW)) bus ();

  dmem_lsu #(.DATA_W(32), .MEM_DEPTH(4096), .MEM_DEPTH_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Read-first RAM with registered read
  logic [31:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bus.o_data_wena) mem[bus.o_data_waddra] <= bus.o_data_dina;
    bus.i_dout_b <= mem[bus.o_addrb];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_wcnt;
    logic [AW-1:0] exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, input logic [31:0] rdata, input logic err,
                              input int wcnt, input logic [AW-1:0] wa, input logic [31:0] wd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_lat = lat; v.exp_rdata = rdata; v.exp_err = err;
    v.exp_wcnt = wcnt; v.exp_wa = wa; v.exp_wd = wd;
    return v;
  endfunction

  task automatic drive(input logic valid, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    bus.i_req_valid    = valid;
    bus.i_req_we       = we;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    bus.i_req_addr     = addr;
    bus.i_req_wdata    = wdata;
  endtask

  // Issue one request and watch four cycles for its write and response pulses
  task automatic do_req(input vec_t v, input string tag);
    int lat, wcnt;
    logic [31:0] rdata, wd;
    logic err, rdy;
    logic [AW-1:0] wa;
    lat = 0; wcnt = 0; rdata = '0; err = 1'b0; wa = '0; wd = '0;
    @(negedge clk);
    rdy = bus.o_req_ready;
    drive(1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      if (bus.o_data_wena) begin
        wcnt++;
        wa = bus.o_data_waddra;
        wd = bus.o_data_dina;
      end
      if (bus.o_rsp_valid && lat == 0) begin
        lat   = c;
        rdata = bus.o_rsp_rdata;
        err   = bus.o_rsp_err;
      end
    end
    $display("txn %s: we=%0d size=%0d addr=0x%08h wdata=0x%08h lat=%0d rdata=0x%08h err=%0d wena=%0d",
             tag, v.we, v.size, v.addr, v.wdata, lat, rdata, err, wcnt);
    check({tag, " ready"}, 32'(rdy), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " rdata"}, rdata, v.exp_rdata);
    check({tag, " err"}, 32'(err), 32'(v.exp_err));
    check({tag, " wena count"}, 32'(wcnt), 32'(v.exp_wcnt));
    if (v.exp_wcnt != 0) begin
      check({tag, " waddra"}, 32'(wa), 32'(v.exp_wa));
      check({tag, " dina"}, wd, v.exp_wd);
    end
  endtask

  vec_t vecs [22];
  int   wena_seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    //        we  size   uns addr          wdata         lat rdata         err wcnt wa      wd
    vecs[0]  = mk(1, 2'b10, 0, 32'h10,       32'hDEADBEEF, 1, 32'h0,        0, 1, 12'h004, 32'hDEADBEEF);
    vecs[1]  = mk(0, 2'b10, 0, 32'h10,       32'h0,        2, 32'hDEADBEEF, 0, 0, 12'h0,   32'h0);
    vecs[2]  = mk(1, 2'b00, 0, 32'h11,       32'h000000A5, 2, 32'h0,        0, 1, 12'h004, 32'hDEADA5EF);
    vecs[3]  = mk(0, 2'b00, 0, 32'h11,       32'h0,        2, 32'hFFFFFFA5, 0, 0, 12'h0,   32'h0);
    vecs[4]  = mk(0, 2'b00, 1, 32'h11,       32'h0,        2, 32'h000000A5, 0, 0, 12'h0,   32'h0);
    vecs[5]  = mk(0, 2'b01, 0, 32'h12,       32'h0,        2, 32'hFFFFDEAD, 0, 0, 12'h0,   32'h0);
    vecs[6]  = mk(0, 2'b01, 1, 32'h12,       32'h0,        2, 32'h0000DEAD, 0, 0, 12'h0,   32'h0);
    vecs[7]  = mk(1, 2'b01, 0, 32'h12,       32'h12345678, 2, 32'h0,        0, 1, 12'h004, 32'h5678A5EF);
    vecs[8]  = mk(0, 2'b10, 0, 32'h10,       32'h0,        2, 32'h5678A5EF, 0, 0, 12'h0,   32'h0);
    vecs[9]  = mk(0, 2'b00, 0, 32'h13,       32'h0,        2, 32'h00000056, 0, 0, 12'h0,   32'h0);
    vecs[10] = mk(0, 2'b00, 1, 32'h10,       32'h0,        2, 32'h000000EF, 0, 0, 12'h0,   32'h0);
    vecs[11] = mk(0, 2'b01, 0, 32'h10,       32'h0,        2, 32'hFFFFA5EF, 0, 0, 12'h0,   32'h0);
    vecs[12] = mk(0, 2'b10, 0, 32'h02,       32'h0,        1, 32'h0,        1, 0, 12'h0,   32'h0);
    vecs[13] = mk(1, 2'b01, 0, 32'h03,       32'h0000BEEF, 1, 32'h0,        1, 0, 12'h0,   32'h0);
    vecs[14] = mk(0, 2'b11, 0, 32'h00,       32'h0,        1, 32'h0,        1, 0, 12'h0,   32'h0);
    vecs[15] = mk(0, 2'b10, 0, 32'h4000,     32'h0,        1, 32'h0,        1, 0, 12'h0,   32'h0);
    vecs[16] = mk(1, 2'b10, 0, 32'h07,       32'h01020304, 1, 32'h0,        1, 0, 12'h0,   32'h0);
    vecs[17] = mk(1, 2'b10, 0, 32'h3FFC,     32'hCAFEF00D, 1, 32'h0,        0, 1, 12'hFFF, 32'hCAFEF00D);
    vecs[18] = mk(0, 2'b10, 0, 32'h3FFC,     32'h0,        2, 32'hCAFEF00D, 0, 0, 12'h0,   32'h0);
    vecs[19] = mk(1, 2'b00, 0, 32'h3FFF,     32'h00000080, 2, 32'h0,        0, 1, 12'hFFF, 32'h80FEF00D);
    vecs[20] = mk(0, 2'b00, 0, 32'h3FFF,     32'h0,        2, 32'hFFFFFF80, 0, 0, 12'h0,   32'h0);
    vecs[21] = mk(1, 2'b10, 0, 32'h80000010, 32'h11111111, 1, 32'h0,        1, 0, 12'h0,   32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ready", 32'(bus.o_req_ready), 32'd0);
    check("reset rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("reset rsp_err", 32'(bus.o_rsp_err), 32'd0);
    check("reset wena", 32'(bus.o_data_wena), 32'd0);
    check("reset rdata", bus.o_rsp_rdata, 32'h0);
    check("reset waddra", 32'(bus.o_data_waddra), 32'h0);
    check("reset dina", bus.o_data_dina, 32'h0);
    rst = 1'b1;
    #1;
    check("ready after release", 32'(bus.o_req_ready), 32'd1);

    for (int i = 0; i < 22; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // SW then colliding LH on the next cycle: must see the just-written word
    @(negedge clk);
    check("fwd sw ready", 32'(bus.o_req_ready), 32'd1);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    @(negedge clk);
    check("fwd sw rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    check("fwd sw wena", 32'(bus.o_data_wena), 32'd1);
    check("fwd sw waddra", 32'(bus.o_data_waddra), 32'd8);
    check("fwd lh ready", 32'(bus.o_req_ready), 32'd1);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("fwd lh early rsp", 32'(bus.o_rsp_valid), 32'd0);
    @(negedge clk);
    check("fwd lh rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    check("fwd lh rdata", bus.o_rsp_rdata, 32'h00001122);
    check("fwd lh err", 32'(bus.o_rsp_err), 32'd0);
    $display("txn fwd: SW 0x20=0x11223344 then LH 0x22 rdata=0x%08h", bus.o_rsp_rdata);

    // Four back-to-back word stores
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("b2b%0d rsp_valid", i - 1), 32'(bus.o_rsp_valid), 32'd1);
        check($sformatf("b2b%0d wena", i - 1), 32'(bus.o_data_wena), 32'd1);
        check($sformatf("b2b%0d waddra", i - 1), 32'(bus.o_data_waddra), 32'(i - 1));
        check($sformatf("b2b%0d dina", i - 1), bus.o_data_dina, 32'h1000 + 32'(i - 1));
        $display("txn b2b%0d: waddra=%0d dina=0x%08h", i - 1, bus.o_data_waddra, bus.o_data_dina);
      end
      if (i < 4) begin
        check($sformatf("b2b%0d ready", i), 32'(bus.o_req_ready), 32'd1);
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'h1000 + 32'(i));
      end else begin
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      end
    end
    @(negedge clk);
    check("b2b wena idle", 32'(bus.o_data_wena), 32'd0);
    do_req(mk(0, 2'b10, 0, 32'h0C, 32'h0, 2, 32'h00001003, 0, 0, 12'h0, 32'h0), "b2b_rd");

    // Reset asserted in the RMW cycle of an SH: the write must be dropped
    do_req(mk(1, 2'b10, 0, 32'h40, 32'h55667788, 1, 32'h0, 0, 1, 12'h010, 32'h55667788), "rst_pre");
    @(negedge clk);
    check("rst sh ready", 32'(bus.o_req_ready), 32'd1);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h40, 32'h0000AAAA);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("rst ready low", 32'(bus.o_req_ready), 32'd0);
    wena_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.o_data_wena) wena_seen++;
      if (bus.o_rsp_valid) wena_seen++;
    end
    check("rst ready held low", 32'(bus.o_req_ready), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.o_data_wena) wena_seen++;
      if (bus.o_rsp_valid) wena_seen++;
    end
    check("rst dropped pulses", 32'(wena_seen), 32'd0);
    check("rst ready after", 32'(bus.o_req_ready), 32'd1);
    do_req(mk(0, 2'b10, 0, 32'h40, 32'h0, 2, 32'h55667788, 0, 0, 12'h0, 32'h0), "rst_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator that sits between the core execute/memory stage and the dmem simple-dual-port data RAM. It drives the RAM's single full-word write port and its read port. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses, doing read-modify-write for sub-word stores and extract/extend for loads. It checks alignment and range, and forwards same-cycle write data to a colliding read.

Parameters:
DATA_W, 32, data word width (fixed at 32; sub-word lanes assume 4 bytes)
MEM_DEPTH, 4096, RAM depth in words
MEM_DEPTH_W, clogb2(MEM_DEPTH), RAM word-address width
U_DLY, 1, simulation delay on registered assignments

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&&ready
i_req_we  in  1  1=store, 0=load
i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
i_req_unsigned  in  1  load zero-extend (LBU/LHU)
i_req_addr  in  32  byte address
i_req_wdata  in  DATA_W  store data, right-aligned
o_rsp_valid  out  1  one-cycle response pulse, one per accepted request
o_rsp_rdata  out  DATA_W  load result (0 for stores/errors)
o_rsp_err  out  1  misaligned/out-of-range/illegal size
o_data_wena  out  1  RAM write enable
o_data_waddra  out  MEM_DEPTH_W  RAM write word address
o_data_dina  out  DATA_W  RAM write data
o_addrb  out  MEM_DEPTH_W  RAM read word address
i_dout_b  in  DATA_W  RAM read data, valid one cycle after o_addrb

Behaviour:
- Reset (rst=0, async): state IDLE. o_req_ready, o_rsp_valid, o_rsp_err, o_data_wena = 0. o_rsp_rdata, o_data_waddra, o_data_dina = 0. A pending write or response is dropped. After release, o_req_ready=1.
- States: IDLE, LD (load data returning), RMW (sub-word store merge). o_req_ready = (state==IDLE) and out of reset.
- Word index is i_req_addr[MEM_DEPTH_W+1:2]. o_addrb is combinational from i_req_addr while in IDLE and is held from the captured request in LD/RMW.
- Error check happens at accept. An error is raised when:
  - size==11, or
  - half-word access with addr[0]=1, or
  - word access with addr[1:0]!=0, or
  - any of addr[31:MEM_DEPTH_W+2] is nonzero.
- On error: no RAM write. Next cycle o_rsp_valid=1, o_rsp_err=1, rdata=0. Stay in IDLE.
- Word store accepted at cycle 0 (state stays IDLE):
  - cycle 1: o_data_wena=1, waddra=index, dina=wdata, o_rsp_valid=1.
  - Back-to-back word stores sustain 1 per cycle.
- Sub-word store accepted at cycle 0 → RMW.
  - cycle 1: merge the read word (after forwarding) with wdata[7:0] into byte lane addr[1:0] for SB, or wdata[15:0] into half-lane addr[1] for SH. Register the write. Go to IDLE.
  - cycle 2: o_data_wena=1 and o_rsp_valid=1.
- Load accepted at cycle 0 → LD.
  - cycle 1: extract the lane. Sign-extend unless i_req_unsigned; word loads are passed through. Register the response. Go to IDLE.
  - cycle 2: o_rsp_valid=1 with data.
- Forwarding: in the cycle i_dout_b is consumed, if the RAM was written in the read-issue cycle (o_data_wena=1 and o_data_waddra==read index), use the registered o_data_dina instead of i_dout_b.
- o_data_wena, o_rsp_valid, and o_rsp_err are single-cycle pulses. There is no backpressure on responses; the consumer must always accept.
- A new request may be accepted in the same cycle a response/write pulse is output.

Test Plan:
- Reset low mid-RMW, after SH accept, with rst asserted in cycle 1 → o_data_wena never pulses; o_req_ready=0 during reset; after release, a LW of that address returns the old value.
- SW 0x0000_0010 ← 0xDEADBEEF, then LW 0x10 → cycle-1 wena=1, waddra=4; the load returns rdata=0xDEADBEEF, err=0, 2 cycles after accept.
- Word 0x10=0xDEADBEEF; SB 0x11 ← 0xA5, then LB 0x11 and LBU 0x11 → word becomes 0xDEADA5EF; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- SW 0x20 ← 0x11223344 followed next cycle by LH 0x22 (read collides with the write) → forwarding gives rdata=0x00001122, not stale RAM data.
- LW 0x02, SH 0x03, size=11, and LW 0x4000 (MEM_DEPTH=4096) → each gives rsp_valid with err=1, rdata=0, and no wena.
- Four back-to-back SW to 0x0,0x4,0x8,0xC → ready stays 1; four consecutive wena/rsp pulses with waddra 0,1,2,3.
